// File: rtl/hbridge_guard.sv
// H-bridge drive protection: dead time on every drive entry, latching shoot-through faults,
// and an optional maximum on-time limiter compiled in with `define HBRIDGE_MAX_ON_EN.
module hbridge_guard #(
    parameter int NUM_BRIDGES   = 7,
    parameter int DEAD_CYCLES   = 8,
    parameter int MAX_ON_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_sn,
    input  logic [2*NUM_BRIDGES-1:0] hbridge_in,
    input  logic                     fault_clear,
    output logic [2*NUM_BRIDGES-1:0] hbridge_out,
    output logic [NUM_BRIDGES-1:0]   fault,
    output logic                     fault_any
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DEAD    = 3'd1;
    localparam logic [2:0] S_DRIVE_A = 3'd2;
    localparam logic [2:0] S_DRIVE_B = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
`ifdef HBRIDGE_MAX_ON_EN
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MAX_ON_CYCLES - 1);
`endif

    if (DEAD_CYCLES < 1 || MAX_ON_CYCLES < 1 ||
        (64'(1) << CNT_W) <= 64'(DEAD_CYCLES) ||
        (64'(1) << CNT_W) <= 64'(MAX_ON_CYCLES)) begin : g_bad_params
        $error("hbridge_guard: illegal DEAD_CYCLES/MAX_ON_CYCLES/CNT_W combination");
    end

    logic [NUM_BRIDGES-1:0] w_fault_next;
    logic                   r_fault_any;

    for (genvar k = 0; k < NUM_BRIDGES; k++) begin : g_bridge
        logic [2:0]       r_state;
        logic [2:0]       w_state_next;
        logic             r_target;      // 0 = side A, 1 = side B
        logic             w_target_next;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;
        logic [1:0]       r_out;
        logic             r_fault;
        logic [1:0]       w_req;

        assign w_req = hbridge_in[2*k +: 2];

        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        always_comb begin
            w_state_next  = r_state;
            w_target_next = r_target;
            w_cnt_next    = r_cnt;
            if (w_req == 2'b11) begin
                w_state_next = S_FAULT;
                w_cnt_next   = '0;
            end else if (r_state == S_FAULT) begin
                if (fault_clear && w_req == 2'b00) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            end else if (enable_sn) begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_req != 2'b00) begin
                            w_state_next  = S_DEAD;
                            w_target_next = w_req[1];
                            w_cnt_next    = DEAD_LOAD;
                        end
                    end
                    S_DEAD: begin
                        if (w_req == 2'b00) begin
                            w_state_next = S_IDLE;
                            w_cnt_next   = '0;
                        end else if (w_req[1] == r_target) begin
                            if (r_cnt == '0) begin
                                w_state_next = r_target ? S_DRIVE_B : S_DRIVE_A;
                            end else begin
                                w_cnt_next = r_cnt - 1'b1;
                            end
                        end else begin
                            w_target_next = w_req[1];
                            w_cnt_next    = DEAD_LOAD;
                        end
                    end
                    S_DRIVE_A, S_DRIVE_B: begin
                        if (w_req == 2'b00) begin
                            w_state_next = S_IDLE;
                            w_cnt_next   = '0;
                        end else if (w_req[1] != (r_state == S_DRIVE_B)) begin
                            w_state_next  = S_DEAD;
                            w_target_next = w_req[1];
                            w_cnt_next    = DEAD_LOAD;
                        end else begin
`ifdef HBRIDGE_MAX_ON_EN
                            if (r_cnt == ON_LAST) begin
                                w_state_next = S_FAULT;
                                w_cnt_next   = '0;
                            end else begin
                                w_cnt_next = r_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end
                endcase
            end
        end

        assign w_fault_next[k] = (w_state_next == S_FAULT);

        // NOTE: state registers use non-blocking assignments so all bridges update from the same pre-edge values.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_state  <= S_IDLE;
                r_target <= 1'b0;
                r_cnt    <= '0;
                r_out    <= 2'b00;
                r_fault  <= 1'b0;
            end else begin
                r_state  <= w_state_next;
                r_target <= w_target_next;
                r_cnt    <= w_cnt_next;
                r_out    <= (w_state_next == S_DRIVE_A) ? 2'b01 :
                            (w_state_next == S_DRIVE_B) ? 2'b10 : 2'b00;
                r_fault  <= w_fault_next[k];
            end
        end

        assign hbridge_out[2*k +: 2] = r_out;
        assign fault[k]              = r_fault;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fault_any <= 1'b0;
        end else begin
            r_fault_any <= |w_fault_next;
        end
    end

    assign fault_any = r_fault_any;

endmodule

// File: doc/hbridge_guard.md
# hbridge_guard

Protection stage between the cells controller and the off-chip H-bridge drivers. It consumes the packed `{cols_hbrige, rows_hbrige}` drive pattern and applies three rules per bridge before the pattern reaches the pads:
- guaranteed dead time on every drive entry;
- an optional maximum on-time limiter;
- latching shoot-through/timeout faults.

All bridges are independent copies of one per-channel FSM.

## Interface
Parameters:
- `NUM_BRIDGES`, default 7: bridge count; 5 rows + 2 cols.
- `DEAD_CYCLES`, default 8: dead-time length in clocks. Must be ≥1.
- `MAX_ON_CYCLES`, default 50000: on-time limit in clocks. Must be ≥1.
- `CNT_W`, default 16: counter width. Must satisfy 2^CNT_W > max(DEAD_CYCLES, MAX_ON_CYCLES).

Ports:
- `clock`, in, 1: system clock; shared with the cells controller.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable_sn`, in, 1: synchronised active-low enable, the same net the cells controller uses.
- `hbridge_in`, in, 2*NUM_BRIDGES: requested drive. Bit 2k is side A and bit 2k+1 is side B of bridge k. Bridges 0–4 are the rows and bridges 5–6 are the cols.
- `fault_clear`, in, 1: level; clears faulted bridges whose request is 00.
- `hbridge_out`, out, 2*NUM_BRIDGES: protected drive to the pads. Same bit mapping as `hbridge_in`.
- `fault`, out, NUM_BRIDGES: per-bridge latched fault.
- `fault_any`, out, 1: registered OR of the next-state `fault` vector.

## Operation
Each bridge k has states IDLE, DEAD, DRIVE_A, DRIVE_B and FAULT. It has a target register (A or B) and one shared counter `cnt`.

Request decode from `hbridge_in[2k+1:2k]`:
- 00 = off
- 01 = A
- 10 = B
- 11 = illegal

Request 11 overrides every other transition.

State behaviour:
- **IDLE:** out 00. Request A or B moves to DEAD with target = request and `cnt` = DEAD_CYCLES−1.
- **DEAD:** out 00.
  - Request off → IDLE.
  - Request equal to target: `cnt` decrements. When `cnt` = 0, move to DRIVE_target with `cnt` = 0.
  - Request is the other direction: target = new request, `cnt` reloads to DEAD_CYCLES−1.
- **DRIVE_A / DRIVE_B:** out 01 / 10.
  - Request off → IDLE.
  - Request is the opposite direction → DEAD with the new target and `cnt` reloaded. Out is 00 from the next edge.
  - Request unchanged → `cnt` increments.
  - Timeout (macro builds only): request unchanged with `cnt` = MAX_ON_CYCLES−1 → FAULT.
- **Any state, request 11:** → FAULT. Out is 00 from the next edge.
- **FAULT:** out 00, `fault[k]` = 1. Move to IDLE only when `fault_clear` = 1 and the request is 00 in the same cycle. A request of 11 while in FAULT keeps FAULT.

Enable:
- `enable_sn` = 1 forces every non-FAULT bridge to IDLE with `cnt` = 0, one edge later.
- FAULT states and `fault` bits are preserved while disabled; `fault_clear` still works.

Other rules:
- Outputs are registered decodes of the state. There is no combinational input-to-output path.
- `hbridge_in` is already synchronous to `clock`, so no synchroniser is used.
- The counter never wraps: it is reloaded or cleared on every state entry.

## Timing
- **Reset (asynchronous):** all bridges go to IDLE with `cnt` = 0. `hbridge_out` = 0, `fault` = 0, `fault_any` = 0.
- **Drive latency:** a request first sampled at edge 0 from IDLE gives out 00 through edge DEAD_CYCLES−1. The drive appears after edge DEAD_CYCLES.
- **Drive removal:** a request change to off or to the opposite side removes the drive after the same edge it is sampled (1 cycle).
- **Fault latency:** `fault[k]` and out 00 appear after the sampling edge. `fault_any` follows on the same edge.
- **Timeout:** drive stays asserted for exactly MAX_ON_CYCLES cycles.
- **Reset mid-DEAD or mid-DRIVE:** outputs go low immediately and asynchronously.

## Configuration
- `HBRIDGE_MAX_ON_EN` defined: on-time limiter compiled in, and timeout produces FAULT.
- `HBRIDGE_MAX_ON_EN` undefined:
  - No timeout comparison and no on-count increment; `cnt` is used for dead time only.
  - DRIVE holds indefinitely.
  - FAULT is entered only on request 11.

## Test plan
- **Dead time:** reset, then DEAD_CYCLES=8 and bridge 0 in=01 held → out[1:0]=00 for 8 cycles, then 01 from the 9th cycle after sampling. `fault`=0.
- **Direction swap:** bridge 2 in DRIVE_A, in switched to 10 → out 00 after 1 edge, 8 cycles of 00, then 10. Never 11 on any cycle.
- **Shoot-through:**
  - Bridge 3 in=11 → out 00 next edge, `fault`=0x08, `fault_any`=1.
  - `fault_clear`=1 with in=11 → stays faulted.
  - in=00 with `fault_clear`=1 → IDLE, `fault`=0.
- **Timeout:** MAX_ON_CYCLES=100, bridge 5 in=01 held for 300 cycles → drive for exactly 100 cycles, then `fault[5]`=1. With `HBRIDGE_MAX_ON_EN` undefined → drive for all 292 post-dead cycles, no fault.
- **Enable and reset:**
  - `enable_sn`=1 mid-DRIVE on bridges 0 and 6 → out 0 after 1 edge; an existing `fault[4]` is preserved.
  - `reset` asserted mid-DEAD → all outputs 0 asynchronously.
- **Independence:** all 7 bridges given staggered requests, with one faulting → the other bridges' timing is unaffected cycle-for-cycle.
